instruction_fetch: RTL and testbench

- Fetch stage between the program ROM and the execute/decode stage of the lab CPU.
- Owns the program counter (PC) and drives the ROM address; the ROM responds combinationally in the same cycle.
- Latches the returned 28-bit word into a registered instruction register (IR) with a valid flag.
- Resolves `JMP locally with zero penalty, and accepts stall and branch-redirect requests from execute.

---
 rtl/instruction_fetch_pkg.sv | 27 ++
 rtl/fetch_next_pc.sv | 34 +++
 rtl/instruction_fetch.sv | 113 +++++++++++
 tb/tb_instruction_fetch.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage of the lab CPU.
//   - Opcode encodings (NOP, JMP, BLE) used by fetch and the testbench.
//   - Instruction field positions (opcode, JMP target).
//   - Fetch FSM state encoding.
//   - Helper to extract the opcode from an instruction word.
package instruction_fetch_pkg;

    localparam int unsigned OPCODE_MSB  = 27;
    localparam int unsigned OPCODE_LSB  = 24;
    localparam int unsigned JMP_TGT_MSB = 23;
    localparam int unsigned JMP_TGT_LSB = 16;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_BLE = 4'hC;
    localparam logic [3:0] OP_JMP = 4'hD;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } fetch_state_t;

    function automatic logic [3:0] opcode_of(input logic [27:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection for the fetch stage.
//   pc            : current program counter
//   instr         : ROM word currently addressed by pc
//   branch_taken  : redirect request from execute (highest priority)
//   branch_target : redirect address
//   next_pc       : redirect target, else zero-extended JMP target, else pc+1 (wraps)
module fetch_next_pc
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned INSTR_WIDTH = 28
) (
    input  logic [ADDR_WIDTH-1:0]  pc,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    output logic [ADDR_WIDTH-1:0]  next_pc
);

    logic [7:0] jmp_target;

    assign jmp_target = instr[JMP_TGT_MSB:JMP_TGT_LSB];

    always_comb begin
        // Natural overflow of the adder gives the FFFF -> 0000 wrap.
        next_pc = pc + ADDR_WIDTH'(1);
        if (branch_taken) begin
            next_pc = branch_target;
        end else if (instr[OPCODE_MSB:OPCODE_LSB] == OP_JMP) begin
            next_pc = ADDR_WIDTH'(jmp_target);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses the combinational program ROM and registers the
// returned word into the instruction register presented to execute.
//   Clock, Reset   : clock; asynchronous active-low reset
//   oAddress       : ROM address (the PC itself)
//   iInstruction   : ROM data for oAddress, same cycle
//   iStall         : execute cannot take a new instruction; hold everything
//   iBranchTaken   : redirect request (overrides stall), target in iBranchTarget
//   oInstruction   : instruction register
//   oValid         : instruction register holds a real instruction, not a bubble
//   oPC            : address the instruction register word came from
// JMP is resolved here with no bubble; a redirect squashes the wrong-path word (one bubble).
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 16,
    parameter int unsigned           INSTR_WIDTH = 28,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   Clock,
    input  logic                   Reset,
    output logic [ADDR_WIDTH-1:0]  oAddress,
    input  logic [INSTR_WIDTH-1:0] iInstruction,
    input  logic                   iStall,
    input  logic                   iBranchTaken,
    input  logic [ADDR_WIDTH-1:0]  iBranchTarget,
    output logic [INSTR_WIDTH-1:0] oInstruction,
    output logic                   oValid,
    output logic [ADDR_WIDTH-1:0]  oPC
);

    localparam logic [INSTR_WIDTH-1:0] NopWord = {OP_NOP, {(INSTR_WIDTH-4){1'b0}}};

    fetch_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic [ADDR_WIDTH-1:0]   opc_q;
    logic [INSTR_WIDTH-1:0]  ir_q;
    logic                    valid_q;
    logic [ADDR_WIDTH-1:0]   next_pc;
    logic                    load;
    logic                    squash;

    fetch_next_pc #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_next_pc (
        .pc            (pc_q),
        .instr         (iInstruction),
        .branch_taken  (iBranchTaken),
        .branch_target (iBranchTarget),
        .next_pc       (next_pc)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        squash  = 1'b0;
        if (iBranchTaken) begin
            squash  = 1'b1;
            state_d = RUN;
        end else begin
            case (state_q)
                // The IR holds a bubble in BOOT, so the first word loads unconditionally.
                BOOT: begin
                    load    = 1'b1;
                    state_d = RUN;
                end
                RUN: begin
                    if (iStall) begin
                        state_d = STALL;
                    end else begin
                        load = 1'b1;
                    end
                end
                STALL: begin
                    if (!iStall) begin
                        load    = 1'b1;
                        state_d = RUN;
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            ir_q    <= NopWord;
            valid_q <= 1'b0;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (squash) begin
                // oPC is left as-is; it is meaningless while oValid is low.
                pc_q    <= next_pc;
                ir_q    <= NopWord;
                valid_q <= 1'b0;
            end else if (load) begin
                pc_q    <= next_pc;
                ir_q    <= iInstruction;
                opc_q   <= pc_q;
                valid_q <= 1'b1;
            end
        end
    end

    assign oAddress     = pc_q;
    assign oInstruction = ir_q;
    assign oValid       = valid_q;
    assign oPC          = opc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    localparam logic [27:0] NopWord = {OP_NOP, 24'd0};

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] oAddress;
    logic [27:0] iInstruction;
    logic        iStall = 1'b0;
    logic        iBranchTaken = 1'b0;
    logic [15:0] iBranchTarget = 16'd0;
    logic [27:0] oInstruction;
    logic        oValid;
    logic [15:0] oPC;

    typedef struct packed {
        logic        valid;
        logic [27:0] instr;
        logic [15:0] opc;
        logic [15:0] addr;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          pushes = 0;
    int          pops   = 0;

    logic [27:0] rom [0:65535];

    // Reference model: architectural fetch pointer plus what execute should currently see.
    logic [15:0] m_pc;
    logic [27:0] m_ir;
    logic [15:0] m_opc;
    logic        m_valid;
    bit          m_boot;

    always #5 Clock = ~Clock;

    assign iInstruction = rom[oAddress];

    instruction_fetch dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .oAddress      (oAddress),
        .iInstruction  (iInstruction),
        .iStall        (iStall),
        .iBranchTaken  (iBranchTaken),
        .iBranchTarget (iBranchTarget),
        .oInstruction  (oInstruction),
        .oValid        (oValid),
        .oPC           (oPC)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 16'd0;
        m_ir    = NopWord;
        m_opc   = 16'd0;
        m_valid = 1'b0;
        m_boot  = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_addr"},  32'(oAddress),     32'd0);
        chk({tag, "_valid"}, 32'(oValid),       32'd0);
        chk({tag, "_instr"}, 32'(oInstruction), 32'(NopWord));
        chk({tag, "_pc"},    32'(oPC),          32'd0);
    endtask

    // One clock of stimulus; the model advances on the same edge and pushes its expectation.
    task automatic step(input logic br, input logic [15:0] tgt, input logic st);
        logic [27:0] word;
        exp_t        e;
        iBranchTaken  = br;
        iBranchTarget = tgt;
        iStall        = st;
        @(posedge Clock);
        word = rom[m_pc];
        if (br) begin
            m_pc    = tgt;
            m_ir    = NopWord;
            m_valid = 1'b0;
            m_boot  = 1'b0;
        end else if (m_boot || !st) begin
            m_ir    = word;
            m_opc   = m_pc;
            m_valid = 1'b1;
            m_pc    = (word[27:24] == OP_JMP) ? {8'd0, word[23:16]} : m_pc + 16'd1;
            m_boot  = 1'b0;
        end
        e.valid = m_valid;
        e.instr = m_ir;
        e.opc   = m_opc;
        e.addr  = m_pc;
        sb.push_back(e);
        pushes++;
        @(negedge Clock);
    endtask

    // Monitor: compares every presented output cycle against the scoreboard head.
    always @(posedge Clock) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            pops++;
            chk("valid", 32'(oValid), 32'(e.valid));
            chk("instr", 32'(oInstruction), 32'(e.instr));
            chk("addr",  32'(oAddress), 32'(e.addr));
            if (e.valid) chk("opc", 32'(oPC), 32'(e.opc));
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if (op == OP_JMP) op = OP_NOP;
            rom[i] = {op, 24'($urandom)};
        end
        rom[5] = {OP_JMP, 8'd2, 16'd0};

        // Reset state, then sequential fetch and the JMP loop 2..5.
        model_reset();
        @(negedge Clock);
        @(negedge Clock);
        check_reset_outputs("rst0");
        Reset = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b0, 16'd0, 1'b0);

        // Reach oPC=7, stall three cycles, release.
        step(1'b1, 16'd6, 1'b0);
        step(1'b0, 16'd0, 1'b0);
        step(1'b0, 16'd0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'd0, 1'b1);
        step(1'b0, 16'd0, 1'b0);
        step(1'b0, 16'd0, 1'b0);

        // Redirect together with stall.
        step(1'b1, 16'd9, 1'b1);
        step(1'b0, 16'd0, 1'b0);
        step(1'b0, 16'd0, 1'b0);

        // Wrap at the top of the address space.
        step(1'b1, 16'hFFFF, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'd0, 1'b0);

        // Redirect beats a JMP fetched in the same cycle.
        step(1'b1, 16'd5, 1'b0);
        step(1'b1, 16'd20, 1'b0);
        step(1'b0, 16'd0, 1'b0);
        step(1'b0, 16'd0, 1'b0);

        // Asynchronous reset mid-stall, no clock edge between assertion and check.
        step(1'b0, 16'd0, 1'b1);
        step(1'b0, 16'd0, 1'b1);
        #2;
        Reset = 1'b0;
        #1;
        check_reset_outputs("async");
        iStall = 1'b0;
        model_reset();
        @(negedge Clock);
        Reset = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, 16'd0, 1'b0);

        // Randomised phase with JMPs anywhere in the ROM.
        for (int i = 0; i < 65536; i++) rom[i] = 28'($urandom);
        for (int i = 0; i < 600; i++) begin
            logic        br;
            logic        st;
            logic [15:0] tgt;
            br  = ($urandom_range(0, 11) == 0);
            st  = ($urandom_range(0, 3) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            step(br, tgt, st);
        end

        iStall       = 1'b0;
        iBranchTaken = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        chk("drain", 32'(sb.size()), 32'd0);
        chk("pops", 32'(pops), 32'(pushes));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
